id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand logic for the 5-stage pipelined CPU.
- Captures decoded ID-stage fields each cycle and decodes ALUOp/funct into the 3-bit ALU control code.
- Forwards results from EX/MEM and MEM/WB to produce the ALU's Signal, dataA and dataB.
- Also flags load-use hazards so the hazard/PC logic can hold IF/ID and flush this stage.

---
 rtl/id_ex_if.sv | 64 ++++++
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// id_ex_if: groups the ID/EX stage's pipeline-facing signals.
//   Controls : stall, flush (driven by the hazard/PC logic)
//   ID side  : id_* decoded fields, register indices and register-file read data
//   Bypass   : mem_* (EX/MEM) and wb_* (MEM/WB) write-back information used for forwarding
//   EX side  : aluSignal/aluA/aluB/ex_storeData operands, registered ex_* controls
//   Hazard   : loadUseHazard (combinational load-use detect)
// The slave modport is the stage; the master modport is whoever drives the pipeline around it.
interface id_ex_if #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
);
    logic               stall;
    logic               flush;
    logic [WIDTH-1:0]   id_rsData;
    logic [WIDTH-1:0]   id_rtData;
    logic [WIDTH-1:0]   id_imm;
    logic [REGBITS-1:0] id_rs;
    logic [REGBITS-1:0] id_rt;
    logic [REGBITS-1:0] id_rd;
    logic [5:0]         id_funct;
    logic [1:0]         id_aluOp;
    logic               id_aluSrc;
    logic               id_regDst;
    logic               id_regWrite;
    logic               id_memRead;
    logic               id_memWrite;
    logic               id_memToReg;
    logic               mem_regWrite;
    logic [REGBITS-1:0] mem_writeReg;
    logic [WIDTH-1:0]   mem_result;
    logic               wb_regWrite;
    logic [REGBITS-1:0] wb_writeReg;
    logic [WIDTH-1:0]   wb_result;
    logic [2:0]         aluSignal;
    logic [WIDTH-1:0]   aluA;
    logic [WIDTH-1:0]   aluB;
    logic [WIDTH-1:0]   ex_storeData;
    logic [REGBITS-1:0] ex_writeReg;
    logic               ex_regWrite;
    logic               ex_memRead;
    logic               ex_memWrite;
    logic               ex_memToReg;
    logic               loadUseHazard;

    modport slave (
        input  stall, flush,
        input  id_rsData, id_rtData, id_imm, id_rs, id_rt, id_rd, id_funct, id_aluOp,
        input  id_aluSrc, id_regDst, id_regWrite, id_memRead, id_memWrite, id_memToReg,
        input  mem_regWrite, mem_writeReg, mem_result,
        input  wb_regWrite, wb_writeReg, wb_result,
        output aluSignal, aluA, aluB, ex_storeData, ex_writeReg,
        output ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, loadUseHazard
    );

    modport master (
        output stall, flush,
        output id_rsData, id_rtData, id_imm, id_rs, id_rt, id_rd, id_funct, id_aluOp,
        output id_aluSrc, id_regDst, id_regWrite, id_memRead, id_memWrite, id_memToReg,
        output mem_regWrite, mem_writeReg, mem_result,
        output wb_regWrite, wb_writeReg, wb_result,
        input  aluSignal, aluA, aluB, ex_storeData, ex_writeReg,
        input  ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, loadUseHazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side ALU-control decode, operand
// forwarding and load-use hazard detection.
//   clk   : pipeline clock, all state updates on the rising edge
//   reset : synchronous, active-high; clears every stage register
//   bus   : id_ex_if.slave carrying stall/flush, ID fields, EX/MEM and MEM/WB
//           bypass info, and the EX-side outputs (see id_ex_if.sv)
module id_ex_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic    clk,
    input  logic    reset,
    id_ex_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0]   rs_data;
        logic [WIDTH-1:0]   rt_data;
        logic [WIDTH-1:0]   imm;
        logic [REGBITS-1:0] rs;
        logic [REGBITS-1:0] rt;
        logic [REGBITS-1:0] write_reg;
        logic [2:0]         alu_signal;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
    } ex_regs_t;

    ex_regs_t         ex_d, ex_q;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] fwd_a, fwd_b;
    logic             mem_fwd_ok, wb_fwd_ok;

    // Unknown R-type funct maps to 3'b011, which the ALU treats as "output zero".
    always_comb begin
        alu_ctrl = 3'b011;
        case (bus.id_aluOp)
            2'b00: alu_ctrl = 3'b010;
            2'b01: alu_ctrl = 3'b110;
            2'b11: alu_ctrl = 3'b001;
            default: begin
                case (bus.id_funct)
                    6'd32:   alu_ctrl = 3'b010;
                    6'd34:   alu_ctrl = 3'b110;
                    6'd36:   alu_ctrl = 3'b000;
                    6'd37:   alu_ctrl = 3'b001;
                    6'd42:   alu_ctrl = 3'b111;
                    default: alu_ctrl = 3'b011;
                endcase
            end
        endcase
    end

    // Flush takes priority over stall so a bubble can be inserted while the front end is frozen.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d            = '0;
            ex_d.alu_signal = 3'b010;
        end else if (!bus.stall) begin
            ex_d.rs_data    = bus.id_rsData;
            ex_d.rt_data    = bus.id_rtData;
            ex_d.imm        = bus.id_imm;
            ex_d.rs         = bus.id_rs;
            ex_d.rt         = bus.id_rt;
            ex_d.write_reg  = bus.id_regDst ? bus.id_rd : bus.id_rt;
            ex_d.alu_signal = alu_ctrl;
            ex_d.alu_src    = bus.id_aluSrc;
            ex_d.reg_write  = bus.id_regWrite;
            ex_d.mem_read   = bus.id_memRead;
            ex_d.mem_write  = bus.id_memWrite;
            ex_d.mem_to_reg = bus.id_memToReg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Register 0 is hardwired, so a write to it is never a valid forwarding source.
    assign mem_fwd_ok = bus.mem_regWrite && (bus.mem_writeReg != '0);
    assign wb_fwd_ok  = bus.wb_regWrite  && (bus.wb_writeReg  != '0);

    // WB is applied first and MEM last so the younger EX/MEM result wins.
    always_comb begin
        fwd_a = ex_q.rs_data;
        fwd_b = ex_q.rt_data;
        if (wb_fwd_ok && bus.wb_writeReg == ex_q.rs)   fwd_a = bus.wb_result;
        if (mem_fwd_ok && bus.mem_writeReg == ex_q.rs) fwd_a = bus.mem_result;
        if (wb_fwd_ok && bus.wb_writeReg == ex_q.rt)   fwd_b = bus.wb_result;
        if (mem_fwd_ok && bus.mem_writeReg == ex_q.rt) fwd_b = bus.mem_result;
    end

    assign bus.aluA         = fwd_a;
    assign bus.aluB         = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign bus.ex_storeData = fwd_b;
    assign bus.aluSignal    = ex_q.alu_signal;
    assign bus.ex_writeReg  = ex_q.write_reg;
    assign bus.ex_regWrite  = ex_q.reg_write;
    assign bus.ex_memRead   = ex_q.mem_read;
    assign bus.ex_memWrite  = ex_q.mem_write;
    assign bus.ex_memToReg  = ex_q.mem_to_reg;

    // Deliberately not gated by stall: the hazard unit needs to see it while it holds the front end.
    assign bus.loadUseHazard = ex_q.mem_read && (ex_q.write_reg != '0) &&
                               ((ex_q.write_reg == bus.id_rs) || (ex_q.write_reg == bus.id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_if #(.WIDTH(32), .REGBITS(5)) bus ();

    id_ex_stage #(.WIDTH(32), .REGBITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the EX stage currently holds, in instruction terms.
    logic        m_ok = 1'b0;
    logic [2:0]  m_op;
    logic        m_src, m_rw, m_mr, m_mw, m_mtr;
    logic [4:0]  m_dst, m_rs, m_rt;
    logic [31:0] m_a, m_b, m_imm;

    function automatic logic [2:0] op_code(input logic [1:0] op, input logic [5:0] funct);
        if (op == 2'd0) return 3'b010;
        if (op == 2'd1) return 3'b110;
        if (op == 2'd3) return 3'b001;
        case (int'(funct))
            32: return 3'b010;
            34: return 3'b110;
            36: return 3'b000;
            37: return 3'b001;
            42: return 3'b111;
            default: return 3'b011;
        endcase
    endfunction

    function automatic logic [31:0] bypass(input logic [4:0] r, input logic [31:0] own);
        if (r != 0 && bus.mem_regWrite && bus.mem_writeReg == r) return bus.mem_result;
        if (r != 0 && bus.wb_regWrite && bus.wb_writeReg == r)   return bus.wb_result;
        return own;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ok <= 1'b1;
            {m_op, m_src, m_rw, m_mr, m_mw, m_mtr, m_dst, m_rs, m_rt, m_a, m_b, m_imm} <= '0;
        end else if (bus.flush) begin
            {m_src, m_rw, m_mr, m_mw, m_mtr, m_dst, m_rs, m_rt, m_a, m_b, m_imm} <= '0;
            m_op <= 3'b010;
        end else if (!bus.stall) begin
            m_op  <= op_code(bus.id_aluOp, bus.id_funct);
            m_src <= bus.id_aluSrc;
            m_rw  <= bus.id_regWrite;
            m_mr  <= bus.id_memRead;
            m_mw  <= bus.id_memWrite;
            m_mtr <= bus.id_memToReg;
            m_dst <= bus.id_regDst ? bus.id_rd : bus.id_rt;
            m_rs  <= bus.id_rs;
            m_rt  <= bus.id_rt;
            m_a   <= bus.id_rsData;
            m_b   <= bus.id_rtData;
            m_imm <= bus.id_imm;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_aluSignal", 32'(bus.aluSignal), 32'(m_op));
            chk("m_aluA", bus.aluA, bypass(m_rs, m_a));
            chk("m_aluB", bus.aluB, m_src ? m_imm : bypass(m_rt, m_b));
            chk("m_storeData", bus.ex_storeData, bypass(m_rt, m_b));
            chk("m_writeReg", 32'(bus.ex_writeReg), 32'(m_dst));
            chk("m_ctrl", 32'({bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite, bus.ex_memToReg}),
                32'({m_rw, m_mr, m_mw, m_mtr}));
            chk("m_loadUse", 32'(bus.loadUseHazard),
                32'(m_mr && m_dst != 0 && (m_dst == bus.id_rs || m_dst == bus.id_rt)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [1:0] op; logic [5:0] funct; logic [2:0] exp; } dec_t;
    dec_t dec_tab[9] = '{
        '{2'b10, 6'd32, 3'b010}, '{2'b10, 6'd34, 3'b110}, '{2'b10, 6'd36, 3'b000},
        '{2'b10, 6'd37, 3'b001}, '{2'b10, 6'd42, 3'b111}, '{2'b10, 6'd0,  3'b011},
        '{2'b00, 6'd34, 3'b010}, '{2'b01, 6'd32, 3'b110}, '{2'b11, 6'd42, 3'b001}
    };

    initial begin
        reset = 1'b1;
        bus.stall = 0; bus.flush = 0;
        bus.id_rsData = 32'hDEAD_0001; bus.id_rtData = 32'hDEAD_0002; bus.id_imm = 32'h7;
        bus.id_rs = 5'd3; bus.id_rt = 5'd4; bus.id_rd = 5'd6; bus.id_funct = 6'd32; bus.id_aluOp = 2'b10;
        bus.id_aluSrc = 0; bus.id_regDst = 1; bus.id_regWrite = 1;
        bus.id_memRead = 0; bus.id_memWrite = 0; bus.id_memToReg = 0;
        bus.mem_regWrite = 1; bus.mem_writeReg = 5'd0; bus.mem_result = 32'hBAD0_BAD0;
        bus.wb_regWrite = 0; bus.wb_writeReg = 5'd0; bus.wb_result = 32'h0;

        cyc(); cyc();
        chk("rst_aluA", bus.aluA, 32'h0);
        chk("rst_aluB", bus.aluB, 32'h0);
        chk("rst_regWrite", 32'(bus.ex_regWrite), 32'h0);
        chk("rst_aluSignal", 32'(bus.aluSignal), 32'h0);
        chk("rst_loadUse", 32'(bus.loadUseHazard), 32'h0);
        reset = 1'b0;

        foreach (dec_tab[i]) begin
            bus.id_aluOp = dec_tab[i].op;
            bus.id_funct = dec_tab[i].funct;
            cyc();
            chk($sformatf("dec_%0d", i), 32'(bus.aluSignal), 32'(dec_tab[i].exp));
        end

        bus.mem_regWrite = 0;
        bus.id_rs = 5'd8; bus.id_rsData = 32'h99;
        cyc();
        bus.mem_regWrite = 1; bus.mem_writeReg = 5'd8; bus.mem_result = 32'h11;
        bus.wb_regWrite = 1;  bus.wb_writeReg = 5'd8;  bus.wb_result = 32'h22;
        #1 chk("fwd_mem_wins", bus.aluA, 32'h11);
        bus.mem_regWrite = 0;
        #1 chk("fwd_wb", bus.aluA, 32'h22);
        bus.mem_regWrite = 1; bus.mem_writeReg = 5'd0;
        #1 chk("fwd_r0_mem", bus.aluA, 32'h22);
        bus.wb_regWrite = 0;
        #1 chk("fwd_none", bus.aluA, 32'h99);

        bus.id_aluSrc = 1; bus.id_imm = 32'hFFFF_FFFC; bus.id_rt = 5'd5; bus.id_rtData = 32'h1;
        cyc();
        bus.mem_regWrite = 1; bus.mem_writeReg = 5'd5; bus.mem_result = 32'h55;
        #1 chk("imm_aluB", bus.aluB, 32'hFFFF_FFFC);
        chk("imm_store", bus.ex_storeData, 32'h55);
        bus.mem_regWrite = 0;

        bus.id_memRead = 1; bus.id_regWrite = 1; bus.id_memToReg = 1; bus.id_regDst = 0;
        bus.id_rt = 5'd9; bus.id_rs = 5'd1; bus.id_aluOp = 2'b00;
        cyc();
        bus.id_memRead = 0; bus.id_memToReg = 0; bus.id_rs = 5'd9; bus.id_rt = 5'd2;
        #1 chk("lu_detect", 32'(bus.loadUseHazard), 32'h1);
        bus.flush = 1;
        cyc();
        bus.flush = 0;
        chk("lu_memRead", 32'(bus.ex_memRead), 32'h0);
        chk("lu_regWrite", 32'(bus.ex_regWrite), 32'h0);
        chk("lu_aluSignal", 32'(bus.aluSignal), 32'b010);
        chk("lu_cleared", 32'(bus.loadUseHazard), 32'h0);

        bus.id_rs = 5'd3; bus.id_rsData = 32'h333; bus.id_aluOp = 2'b10; bus.id_funct = 6'd36;
        bus.id_regDst = 1; bus.id_rd = 5'd7; bus.id_aluSrc = 0; bus.id_regWrite = 1;
        cyc();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_rd = 5'(10 + i); bus.id_rsData = $urandom; bus.id_funct = 6'd34;
            cyc();
            chk($sformatf("stall_op_%0d", i), 32'(bus.aluSignal), 32'b000);
            chk($sformatf("stall_dst_%0d", i), 32'(bus.ex_writeReg), 32'd7);
            chk($sformatf("stall_a_%0d", i), bus.aluA, 32'h333);
        end
        bus.flush = 1;
        cyc();
        chk("sf_aluSignal", 32'(bus.aluSignal), 32'b010);
        chk("sf_regWrite", 32'(bus.ex_regWrite), 32'h0);
        chk("sf_writeReg", 32'(bus.ex_writeReg), 32'h0);
        chk("sf_aluA", bus.aluA, 32'h0);

        bus.flush = 0; bus.stall = 0;
        cyc();
        bus.stall = 1; reset = 1;
        cyc();
        reset = 0; bus.stall = 0;
        chk("rst_in_stall", 32'(bus.aluSignal), 32'h0);
        chk("rst_in_stall_dst", 32'(bus.ex_writeReg), 32'h0);
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
